// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared constants and types for the 256x48 SRAM FIFO controller
package sram_fifo_pkg;

    localparam int DATA_WIDTH = 48;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int NUM_WMASKS = 4;

    localparam logic [NUM_WMASKS-1:0] WMASK_ALL = 4'hF;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/sram_fifo_outbuf.sv
// rtl/sram_fifo_outbuf.sv - 2-entry registered skid buffer holding words returned by the SRAM read port
module sram_fifo_outbuf
    import sram_fifo_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   buf_cnt,
    output logic [W-1:0] head_data
);

    logic [W-1:0] tail_data;

    // The controller never pushes into a full buffer unless it pops in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_cnt   <= 2'd0;
            head_data <= '0;
            tail_data <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) head_data <= push_data;
                    else                 tail_data <= push_data;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    if (buf_cnt == 2'd2) head_data <= tail_data;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd2) begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end else begin
                        head_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl_256x48.sv
// rtl/sram_fifo_ctrl_256x48.sv - valid/ready FIFO controller in front of a 256x48 1W1R SRAM macro
module sram_fifo_ctrl_256x48 #(
    parameter int DATA_WIDTH   = sram_fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = sram_fifo_pkg::ADDR_WIDTH,
    parameter int DEPTH        = sram_fifo_pkg::DEPTH,
    parameter int NUM_WMASKS   = sram_fifo_pkg::NUM_WMASKS,
    parameter int AFULL_THRESH = 240
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    import sram_fifo_pkg::*;

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         sram_cnt;
    logic                  inflight;
    logic [1:0]            buf_cnt;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            buf_occ_next;

    assign in_ready = !rst && (sram_cnt < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Buffer slots committed after this edge: a read is issued only if its word will have a slot.
    assign buf_occ_next = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue        = !rst && (sram_cnt != '0) && (buf_occ_next < 3'd2);

    assign sram_csb0   = !push;
    assign sram_addr0  = push ? wr_ptr : '0;
    assign sram_din0   = push ? in_data : '0;
    assign sram_wmask0 = push ? WMASK_ALL : '0;
    assign sram_csb1   = !issue;
    assign sram_addr1  = issue ? rd_ptr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({push, issue})
                2'b10:   sram_cnt <= sram_cnt + CW'(1);
                2'b01:   sram_cnt <= sram_cnt - CW'(1);
                default: ;
            endcase
            inflight <= issue;
        end
    end

    // dout1 is valid during the cycle after a read issue; reset discards it.
    sram_fifo_outbuf #(
        .W (DATA_WIDTH)
    ) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (sram_dout1),
        .pop       (pop),
        .buf_cnt   (buf_cnt),
        .head_data (out_data)
    );

    assign out_valid   = (buf_cnt != 2'd0);
    assign count       = sram_cnt + CW'(inflight) + CW'(buf_cnt);
    assign almost_full = (count >= CW'(AFULL_THRESH));

endmodule

// File: tb/tb_sram_fifo_ctrl_256x48.sv
// tb/tb_sram_fifo_ctrl_256x48.sv - self-checking bench with SRAM model and queue-based reference
module tb_sram_fifo_ctrl_256x48;
    import sram_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    word_t       in_data;
    logic        out_valid;
    logic        out_ready;
    word_t       out_data;
    logic [8:0]  count;
    logic        almost_full;
    logic        sram_csb0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    word_t       sram_din0;
    logic        sram_csb1;
    logic [7:0]  sram_addr1;
    word_t       sram_dout1 = '0;

    always #5 clk = ~clk;

    sram_fifo_ctrl_256x48 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .sram_csb0   (sram_csb0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1)
    );

    // SRAM macro model: synchronous write with lane masks, one-cycle read latency.
    word_t mem [256];
    word_t lane_mask;
    always_comb begin
        lane_mask = '0;
        for (int l = 0; l < 4; l++) lane_mask[l*12 +: 12] = {12{sram_wmask0[l]}};
    end
    always @(posedge clk) begin
        if (!sram_csb0) mem[sram_addr0] <= (mem[sram_addr0] & ~lane_mask) | (sram_din0 & lane_mask);
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: the queue holds every accepted, not yet consumed word in order;
    // m_sram/m_infl/m_buf locate the words between SRAM, read pipe and output buffer.
    word_t      q[$];
    int         m_sram = 0, m_infl = 0, m_buf = 0;
    logic [7:0] m_wr = '0, m_rd = '0;
    bit         e_push, e_pop, e_issue;
    word_t      s_data;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_push  = !rst && in_valid && (m_sram < 256);
            e_pop   = (m_buf != 0) && out_ready;
            e_issue = !rst && (m_sram > 0) && ((m_buf + m_infl - (e_pop ? 1 : 0)) < 2);
            chk("in_ready", in_ready, !rst && (m_sram < 256));
            chk("out_valid", out_valid, m_buf != 0);
            if (m_buf != 0) chk("out_data", out_data, q[0]);
            chk("count", count, q.size());
            chk("almost_full", almost_full, q.size() >= 240);
            chk("csb0", sram_csb0, !e_push);
            chk("addr0", sram_addr0, e_push ? m_wr : 8'h0);
            chk("din0", sram_din0, e_push ? in_data : 48'h0);
            chk("wmask0", sram_wmask0, e_push ? 4'hF : 4'h0);
            chk("csb1", sram_csb1, !e_issue);
            chk("addr1", sram_addr1, e_issue ? m_rd : 8'h0);
            if (!sram_csb0 && !sram_csb1) chk("collision", sram_addr0 != sram_addr1, 1);
            s_data = in_data;
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_sram = 0; m_infl = 0; m_buf = 0;
                m_wr = '0;  m_rd = '0;
            end else begin
                if (e_push) begin
                    q.push_back(s_data);
                    m_wr++;
                end
                if (e_pop) void'(q.pop_front());
                m_buf  = m_buf + m_infl - (e_pop ? 1 : 0);
                m_sram = m_sram + (e_push ? 1 : 0) - (e_issue ? 1 : 0);
                m_infl = e_issue ? 1 : 0;
                if (e_issue) m_rd++;
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (count != 0 && n < 600) begin
            cycle();
            n++;
        end
        chk(name, count, 0);
        out_ready = 1'b0;
    endtask

    int  nxt, got, acc, npop, first, last, bubbles;
    bit  a;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Power-on reset
        cycle();
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_csb0", sram_csb0, 1);
            chk("rst_csb1", sram_csb1, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_count", count, 0);
            cycle();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);

        // Single word
        cycle();
        in_valid = 1'b1; in_data = 48'hA5A5_1234_5678;
        @(negedge clk);
        chk("single_csb0", sram_csb0, 0);
        chk("single_addr0", sram_addr0, 0);
        chk("single_wmask0", sram_wmask0, 4'hF);
        cycle();
        in_valid = 1'b0;
        @(negedge clk); chk("single_valid_e1", out_valid, 0);
        cycle();
        @(negedge clk); chk("single_valid_e2", out_valid, 0);
        cycle();
        @(negedge clk);
        chk("single_valid_e3", out_valid, 1);
        chk("single_data", out_data, 48'hA5A5_1234_5678);
        cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        @(negedge clk);
        chk("single_count_after_pop", count, 0);

        // Fill with consumer stalled, then drain in order
        cycle();
        nxt = 0;
        in_valid = 1'b1;
        repeat (320) begin
            in_data = word_t'(nxt);
            @(negedge clk);
            a = in_ready;
            cycle();
            if (a) nxt++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("fill_accepted", nxt, 258);
        chk("fill_count", count, 258);
        chk("fill_afull", almost_full, 1);
        chk("fill_in_ready", in_ready, 0);
        cycle();
        out_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 400 && count != 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("drain_order", out_data, got);
                got++;
            end
            cycle();
        end
        chk("drain_total", got, 258);
        chk("drain_empty", count, 0);
        out_ready = 1'b0;

        // Streaming at full rate
        in_valid = 1'b1; out_ready = 1'b1;
        first = -1; last = -1; bubbles = 0; npop = 0;
        for (int c = 0; c < 1000; c++) begin
            in_data = word_t'(1000 + c);
            @(negedge clk);
            if (out_valid) begin
                npop++;
                if (last >= 0 && c != last + 1) bubbles++;
                if (first < 0) first = c;
                last = c;
            end
            cycle();
        end
        chk("stream_first_pop", first, 3);
        chk("stream_bubbles", bubbles, 0);
        chk("stream_pops", npop, 997);
        drain("stream_drain");

        // Random backpressure
        acc = 0; npop = 0;
        for (int c = 0; c < 40000 && acc < 5000; c++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            in_data   = word_t'({$urandom(), $urandom()});
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) npop++;
            cycle();
        end
        chk("random_accepted", acc, 5000);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 600 && count != 0; i++) begin
            @(negedge clk);
            if (out_valid) npop++;
            cycle();
        end
        chk("random_lossless", npop, acc);
        out_ready = 1'b0;

        // Reset for 3 cycles in the middle of traffic
        for (int c = 0; c < 200; c++) begin
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 3) == 0;
            in_data   = word_t'({$urandom(), $urandom()});
            cycle();
        end
        in_valid = 1'b1; out_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_csb0", sram_csb0, 1);
        chk("midrst_csb1", sram_csb1, 1);
        repeat (2) begin
            cycle();
            @(negedge clk);
            chk("midrst_out_valid", out_valid, 0);
            chk("midrst_count", count, 0);
            chk("midrst_csb0_b", sram_csb0, 1);
        end
        cycle();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", in_ready, 1);

        // Reset while a read is in flight
        cycle();
        in_valid = 1'b1; in_data = 48'h1111_2222_3333;
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("flight_issue", sram_csb1, 0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("flight_out_valid", out_valid, 0);
        chk("flight_count", count, 0);
        cycle();
        @(negedge clk);
        chk("flight_out_valid_late", out_valid, 0);
        cycle();
        in_valid = 1'b1; in_data = 48'h0BAD_CAFE_0042;
        @(negedge clk);
        chk("flight_next_addr0", sram_addr0, 0);
        chk("flight_next_csb0", sram_csb0, 0);
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        chk("flight_new_data", out_data, 48'h0BAD_CAFE_0042);
        cycle();
        drain("final_drain");

        repeat (2) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
